// File: rtl/rr_encoder4.sv
// Four-line event encoder: buffers one-hot requests and issues one 2-bit address
// at a time under valid/ready, with round-robin or fixed-priority arbitration.
module rr_encoder4 #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       ready,
  output logic       address0,
  output logic       address1,
  output logic       enable,
  output logic       dropped
);

  logic [3:0] pending;
  logic [3:0] cand;
  logic [3:0] pend_nxt;
  logic [1:0] ptr;
  logic [1:0] addr;
  logic [1:0] idx;
  logic [1:0] scan;
  logic       found;
  logic       load;

  always_comb begin
    cand  = pending | req;
    load  = !enable || ready;
    idx   = '0;
    scan  = '0;
    found = 1'b0;
    // Fixed priority is the rotating scan with its origin pinned at index 0.
    for (int unsigned k = 0; k < 4; k++) begin
      scan = (ROUND_ROBIN != 0) ? ptr + 2'(k) : 2'(k);
      if (!found && cand[scan]) begin
        idx   = scan;
        found = 1'b1;
      end
    end
    pend_nxt = cand;
    if (load && found) begin
      pend_nxt = cand & ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      ptr     <= '0;
      addr    <= '0;
      enable  <= 1'b0;
      dropped <= 1'b0;
    end else begin
      pending <= pend_nxt;
      dropped <= |(req & pending);
      if (load) begin
        if (found) begin
          addr   <= idx;
          enable <= 1'b1;
          if (ROUND_ROBIN != 0) begin
            ptr <= idx + 2'd1;
          end
        end else begin
          enable <= 1'b0;
        end
      end
    end
  end

  assign address0 = addr[0];
  assign address1 = addr[1];

endmodule

// File: tb/tb_rr_encoder4.sv
// Scenario bench for rr_encoder4: a round-robin and a fixed-priority instance
// share stimulus; expected outputs are queued per driven cycle and popped after the edge.
module tb_rr_encoder4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;
  logic       rr_a0, rr_a1, rr_en, rr_drp;
  logic       fp_a0, fp_a1, fp_en, fp_drp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_encoder4 #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(rst), .req(req), .ready(ready),
    .address0(rr_a0), .address1(rr_a1), .enable(rr_en), .dropped(rr_drp)
  );

  rr_encoder4 #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(rst), .req(req), .ready(ready),
    .address0(fp_a0), .address1(fp_a1), .enable(fp_en), .dropped(fp_drp)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       en;
    logic [1:0] addr;
    logic       drp;
    logic       chkd;
    logic       chkfp;
    logic       fen;
    logic [1:0] faddr;
  } step_t;

  step_t exp_q[$];

  function automatic step_t mk(logic r, logic [3:0] q, logic rd, logic en, logic [1:0] a,
                               logic d, logic cd, logic cf, logic fe, logic [1:0] fa);
    step_t s;
    s.rst = r; s.req = q; s.rdy = rd; s.en = en; s.addr = a; s.drp = d;
    s.chkd = cd; s.chkfp = cf; s.fen = fe; s.faddr = fa;
    return s;
  endfunction

  // Reset discards events presented during reset, then a 4-way burst drains 0..3.
  task automatic test_reset();
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 4'b1111, 0, 0, 2'd0, 0, 1, 1, 0, 2'd0));
    tbl.push_back(mk(1, 4'b1111, 0, 0, 2'd0, 0, 1, 1, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 1, 1, 0, 2'd0));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 2'd0, 0, 1, 1, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 0, 1, 1, 1, 2'd1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd2, 0, 1, 1, 1, 2'd2));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd3, 0, 1, 1, 1, 2'd3));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd3, 0, 1, 1, 0, 2'd3));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rr_en, rr_a1, rr_a0} !== {e.en, e.addr}) begin
        errors++;
        $display("FAIL reset[%0d] rr out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, rr_en, {rr_a1, rr_a0}, e.en, e.addr);
      end
      checks++;
      if (rr_drp !== e.drp) begin
        errors++;
        $display("FAIL reset[%0d] dropped: got %b, need %b", i, rr_drp, e.drp);
      end
      checks++;
      if ({fp_en, fp_a1, fp_a0} !== {e.fen, e.faddr}) begin
        errors++;
        $display("FAIL reset[%0d] fp out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, fp_en, {fp_a1, fp_a0}, e.fen, e.faddr);
      end
    end
  endtask

  // Two sources held active alternate 0,3,0,3 with ready held high.
  task automatic test_back_to_back();
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 0, 1, 0, 0, 2'd0));
    for (int k = 0; k < 6; k++) begin
      tbl.push_back(mk(0, 4'b1001, 1, 1, (k % 2 == 0) ? 2'd0 : 2'd3, 0, 0, 0, 0, 2'd0));
    end
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 0, 0, 0, 2'd0));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rr_en, rr_a1, rr_a0} !== {e.en, e.addr}) begin
        errors++;
        $display("FAIL b2b[%0d] rr out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, rr_en, {rr_a1, rr_a0}, e.en, e.addr);
      end
    end
  endtask

  // Address 2 holds through five stalled cycles, then is accepted and the output idles.
  task automatic test_backpressure();
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2'd2, 0, 1, 0, 0, 2'd0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(0, 4'b0000, 0, 1, 2'd2, 0, 1, 0, 0, 2'd0));
    end
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd2, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd2, 0, 1, 0, 0, 2'd0));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rr_en, rr_a1, rr_a0} !== {e.en, e.addr}) begin
        errors++;
        $display("FAIL backpressure[%0d] rr out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, rr_en, {rr_a1, rr_a0}, e.en, e.addr);
      end
      checks++;
      if (rr_drp !== e.drp) begin
        errors++;
        $display("FAIL backpressure[%0d] dropped: got %b, need %b", i, rr_drp, e.drp);
      end
    end
  endtask

  // Repeat of the in-flight index is buffered once, the second repeat is merged.
  task automatic test_inflight_repeat();
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 2'd1, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 2'd1, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 2'd1, 1, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 2'd1, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd1, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd1, 0, 1, 0, 0, 2'd0));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rr_en, rr_a1, rr_a0} !== {e.en, e.addr}) begin
        errors++;
        $display("FAIL inflight[%0d] rr out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, rr_en, {rr_a1, rr_a0}, e.en, e.addr);
      end
      checks++;
      if (rr_drp !== e.drp) begin
        errors++;
        $display("FAIL inflight[%0d] dropped: got %b, need %b", i, rr_drp, e.drp);
      end
    end
  endtask

  // Pending 1011 behind a busy output: fixed priority drains 0,1,3; rotating drains 3,0,1.
  task automatic test_fixed_priority();
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 0, 1, 1, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2'd2, 0, 1, 1, 1, 2'd2));
    tbl.push_back(mk(0, 4'b1010, 0, 1, 2'd2, 0, 1, 1, 1, 2'd2));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 2'd2, 0, 1, 1, 1, 2'd2));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd3, 0, 1, 1, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd0, 0, 1, 1, 1, 2'd1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 0, 1, 1, 1, 2'd3));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd1, 0, 1, 1, 0, 2'd3));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rr_en, rr_a1, rr_a0} !== {e.en, e.addr}) begin
        errors++;
        $display("FAIL priority[%0d] rr out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, rr_en, {rr_a1, rr_a0}, e.en, e.addr);
      end
      checks++;
      if ({fp_en, fp_a1, fp_a0} !== {e.fen, e.faddr}) begin
        errors++;
        $display("FAIL priority[%0d] fp out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, fp_en, {fp_a1, fp_a0}, e.fen, e.faddr);
      end
      checks++;
      if (fp_drp !== e.drp) begin
        errors++;
        $display("FAIL priority[%0d] fp dropped: got %b, need %b", i, fp_drp, e.drp);
      end
    end
  endtask

  // Reset while address 3 is stalled with 0110 pending: nothing comes out afterwards.
  task automatic test_reset_midflight();
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 2'd3, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0110, 0, 1, 2'd3, 0, 1, 0, 0, 2'd0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 0, 1, 0, 0, 2'd0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 1, 0, 0, 2'd0));
    end
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; ready = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rr_en, rr_a1, rr_a0} !== {e.en, e.addr}) begin
        errors++;
        $display("FAIL midreset[%0d] rr out: got en=%b addr=%0d, need en=%b addr=%0d",
                 i, rr_en, {rr_a1, rr_a0}, e.en, e.addr);
      end
      checks++;
      if (rr_drp !== e.drp) begin
        errors++;
        $display("FAIL midreset[%0d] dropped: got %b, need %b", i, rr_drp, e.drp);
      end
    end
  endtask

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_inflight_repeat();
    test_fixed_priority();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
